// File: rtl/mem_sched_pkg.sv
// Shared types and constants for the three-requester RAM slot scheduler.
package mem_sched_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;
  localparam logic [1:0] PHASE_3 = 2'd3;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    LCD  = 2'd2,
    HOST = 2'd3
  } req_id_e;

endpackage

// File: rtl/mem_sched_arb.sv
// Slot arbiter: picks the owner of each two-phase slot and tracks host starvation.
module mem_sched_arb
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    decide,
  input  logic    slot_b,
  input  logic    cpu_req,
  input  logic    lcd_req,
  input  logic    host_req,
  input  req_id_e mask,
  output req_id_e grant_next,
  output req_id_e grant
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  req_id_e       grant_q, grant_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          cpu_eff, lcd_eff, host_eff;

  // A requester finishing at this edge is hidden so a held req does not re-issue at once.
  always_comb begin
    cpu_eff  = cpu_req  && (mask != CPU);
    lcd_eff  = lcd_req  && (mask != LCD);
    host_eff = host_req && (mask != HOST);
    grant_d  = grant_q;
    starve_d = starve_q;
    if (decide) begin
      grant_d = NONE;
      if (!slot_b) begin
        if (host_eff && (starve_q == CW'(STARVE_LIMIT))) grant_d = HOST;
        else if (cpu_eff)                                 grant_d = CPU;
        else if (host_eff)                                grant_d = HOST;
      end else begin
        if (lcd_eff)       grant_d = LCD;
        else if (host_eff) grant_d = HOST;
      end
      if (grant_d == HOST)
        starve_d = '0;
      else if (host_eff && (starve_q != CW'(STARVE_LIMIT)))
        starve_d = starve_q + CW'(1);
    end
  end

  // Grant and starvation count only change at slot boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= NONE;
      starve_q <= '0;
    end else begin
      grant_q  <= grant_d;
      starve_q <= starve_d;
    end
  end

  assign grant_next = grant_d;
  assign grant      = grant_q;

endmodule

// File: rtl/mem_sched.sv
// Time-sliced SRAM scheduler: slot A (phases 0-1) for the CPU, slot B (phases 2-3)
// for the LCD fetch, with the host filling idle slots or forced in when starved.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  input  logic                lcd_req,
  input  logic [ADDR_W-1:0]   lcd_addr,
  output logic [DATA_W-1:0]   lcd_rdata,
  output logic                lcd_ack,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_ack,
  output logic [ADDR_W-1:0]   ram_a,
  output logic [DATA_W-1:0]   ram_di,
  input  logic [DATA_W-1:0]   ram_do,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n,
  output logic [1:0]          phase
);

  logic [1:0]        phase_q, phase_d;
  logic              first_q;
  logic              acc_we_q, acc_we_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_di_q, ram_di_d;
  logic              ram_ce_n_q, ram_ce_n_d;
  logic              ram_oe_n_q, ram_oe_n_d;
  logic              ram_we_n_q, ram_we_n_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] lcd_rdata_q, lcd_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              lcd_ack_q, lcd_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              decide, slot_b, complete;
  req_id_e           mask, grant_next, grant;

  // The first edge after reset re-enters phase 0 so it carries a grant decision.
  assign phase_d  = first_q ? PHASE_0 : phase_q + 2'd1;
  assign decide   = ~phase_d[0];
  assign slot_b   = (phase_d == PHASE_2);
  assign complete = !first_q && phase_q[0] && (grant != NONE);
  assign mask     = complete ? grant : NONE;

  mem_sched_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .decide     (decide),
    .slot_b     (slot_b),
    .cpu_req    (cpu_req),
    .lcd_req    (lcd_req),
    .host_req   (host_req),
    .mask       (mask),
    .grant_next (grant_next),
    .grant      (grant)
  );

  // Strobe sequencing: close the finishing access, pulse the write, then launch the new grant.
  always_comb begin
    acc_we_d     = acc_we_q;
    ram_a_d      = ram_a_q;
    ram_di_d     = ram_di_q;
    ram_ce_n_d   = ram_ce_n_q;
    ram_oe_n_d   = ram_oe_n_q;
    ram_we_n_d   = ram_we_n_q;
    cpu_rdata_d  = cpu_rdata_q;
    lcd_rdata_d  = lcd_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_ack_d    = 1'b0;
    lcd_ack_d    = 1'b0;
    host_ack_d   = 1'b0;

    if (complete) begin
      ram_we_n_d = 1'b1;
      ram_ce_n_d = 1'b1;
      ram_oe_n_d = 1'b1;
      case (grant)
        CPU: begin
          cpu_ack_d = 1'b1;
          if (!acc_we_q) cpu_rdata_d = ram_do;
        end
        LCD: begin
          lcd_ack_d = 1'b1;
          if (!acc_we_q) lcd_rdata_d = ram_do;
        end
        HOST: begin
          host_ack_d = 1'b1;
          if (!acc_we_q) host_rdata_d = ram_do;
        end
        default: ;
      endcase
    end else if (!first_q && !phase_q[0] && (grant != NONE)) begin
      ram_we_n_d = ~acc_we_q;
    end

    if (decide && (grant_next != NONE)) begin
      ram_ce_n_d = 1'b0;
      ram_we_n_d = 1'b1;
      case (grant_next)
        CPU: begin
          ram_a_d    = cpu_addr;
          ram_di_d   = cpu_wdata;
          ram_oe_n_d = cpu_we;
          acc_we_d   = cpu_we;
        end
        LCD: begin
          ram_a_d    = lcd_addr;
          ram_oe_n_d = 1'b0;
          acc_we_d   = 1'b0;
        end
        HOST: begin
          ram_a_d    = host_addr;
          ram_di_d   = host_wdata;
          ram_oe_n_d = host_we;
          acc_we_d   = host_we;
        end
        default: ;
      endcase
    end
  end

  // All outputs come straight from these flops; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PHASE_0;
      first_q      <= 1'b1;
      acc_we_q     <= 1'b0;
      ram_a_q      <= '0;
      ram_di_q     <= '0;
      ram_ce_n_q   <= 1'b1;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      cpu_rdata_q  <= '0;
      lcd_rdata_q  <= '0;
      host_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      lcd_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      first_q      <= 1'b0;
      acc_we_q     <= acc_we_d;
      ram_a_q      <= ram_a_d;
      ram_di_q     <= ram_di_d;
      ram_ce_n_q   <= ram_ce_n_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
      cpu_rdata_q  <= cpu_rdata_d;
      lcd_rdata_q  <= lcd_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      lcd_ack_q    <= lcd_ack_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign phase      = phase_q;
  assign ram_a      = ram_a_q;
  assign ram_di     = ram_di_q;
  assign ram_ce_n   = ram_ce_n_q;
  assign ram_oe_n   = ram_oe_n_q;
  assign ram_we_n   = ram_we_n_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign lcd_rdata  = lcd_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign lcd_ack    = lcd_ack_q;
  assign host_ack   = host_ack_q;

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: reset, single reads/writes, held requests,
// host starvation and reset in the middle of an access.
module tb_mem_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, lcd_req, host_req, host_we;
  logic [18:0] cpu_addr, lcd_addr, host_addr;
  logic [7:0]  cpu_wdata, host_wdata, ram_do;
  logic [7:0]  cpu_rdata, lcd_rdata, host_rdata, ram_di;
  logic        cpu_ack, lcd_ack, host_ack;
  logic [18:0] ram_a;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic [1:0]  phase;

  int checkCount = 0;
  int passCount  = 0;

  logic expCpu, expLcd, expHost;
  logic heldAck [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic heldCe  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  mem_sched #(.STARVE_LIMIT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .lcd_req    (lcd_req),
    .lcd_addr   (lcd_addr),
    .lcd_rdata  (lcd_rdata),
    .lcd_ack    (lcd_ack),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .ram_a      (ram_a),
    .ram_di     (ram_di),
    .ram_do     (ram_do),
    .ram_ce_n   (ram_ce_n),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n),
    .phase      (phase)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main directed sequence; each step lands 1 time unit after a rising edge.
  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    lcd_req = 1'b0; lcd_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    ram_do = '0;
    applyStimulus(3);

    checkOutput("rst phase", phase, 0);
    checkOutput("rst ce_n", ram_ce_n, 1);
    checkOutput("rst oe_n", ram_oe_n, 1);
    checkOutput("rst we_n", ram_we_n, 1);
    checkOutput("rst ram_a", ram_a, 0);
    checkOutput("rst ram_di", ram_di, 0);
    checkOutput("rst acks", {cpu_ack, lcd_ack, host_ack}, 0);
    checkOutput("rst rdata", {cpu_rdata, lcd_rdata, host_rdata}, 0);

    rst = 1'b0;
    applyStimulus(1);
    checkOutput("post-rst phase", phase, 0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("idle phase %0d", i), phase, i % 4);
      checkOutput($sformatf("idle ce_n %0d", i), ram_ce_n, 1);
      checkOutput($sformatf("idle acks %0d", i), {cpu_ack, lcd_ack, host_ack}, 0);
    end

    // CPU read in its own slot.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12345; ram_do = 8'hA5;
    applyStimulus(1);
    checkOutput("cpu rd ram_a", ram_a, 19'h12345);
    checkOutput("cpu rd p0 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b001);
    checkOutput("cpu rd p0 ack", cpu_ack, 0);
    applyStimulus(1);
    checkOutput("cpu rd p1 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b001);
    applyStimulus(1);
    checkOutput("cpu rd ack", cpu_ack, 1);
    checkOutput("cpu rd rdata", cpu_rdata, 8'hA5);
    checkOutput("cpu rd p2 phase", phase, 2);
    checkOutput("cpu rd p2 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    cpu_req = 1'b0;
    applyStimulus(1);
    checkOutput("cpu rd ack pulse", cpu_ack, 0);
    checkOutput("cpu rd rdata hold", cpu_rdata, 8'hA5);
    applyStimulus(1);
    checkOutput("idle slot A ce_n", ram_ce_n, 1);

    // Host write lands in slot B because the LCD is idle.
    host_req = 1'b1; host_we = 1'b1; host_addr = 19'h7FFFF; host_wdata = 8'h3C;
    applyStimulus(1);
    checkOutput("host wr p1 ce_n", ram_ce_n, 1);
    applyStimulus(1);
    checkOutput("host wr ram_a", ram_a, 19'h7FFFF);
    checkOutput("host wr ram_di", ram_di, 8'h3C);
    checkOutput("host wr p2 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b011);
    applyStimulus(1);
    checkOutput("host wr p3 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b010);
    applyStimulus(1);
    checkOutput("host wr ack", host_ack, 1);
    checkOutput("host wr ack phase", phase, 0);
    checkOutput("host wr p0 strobes", {ram_ce_n, ram_we_n}, 2'b11);
    checkOutput("host wr rdata", host_rdata, 0);
    host_req = 1'b0; host_we = 1'b0;
    applyStimulus(1);
    checkOutput("host wr ack pulse", host_ack, 0);

    // CPU holds its request across acks: one access per frame, nothing in slot B.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010; ram_do = 8'h5A;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("held cpu ack %0d", k), cpu_ack, heldAck[k]);
      checkOutput($sformatf("held ce_n %0d", k), ram_ce_n, heldCe[k]);
    end
    checkOutput("held cpu rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    applyStimulus(1);

    // Everyone requesting: host loses 16 slots then takes slot A once.
    cpu_req = 1'b1; lcd_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    lcd_addr = 19'h40000; host_addr = 19'h00200; ram_do = 8'h11;
    for (int s = 1; s <= 41; s++) begin
      applyStimulus(1);
      expCpu  = (((s % 4) == 3) && (s <= 31)) || (s == 39);
      expLcd  = ((s % 4) == 1) && (s >= 5);
      expHost = (s == 35);
      checkOutput($sformatf("starve cpu_ack s%0d", s), cpu_ack, expCpu);
      checkOutput($sformatf("starve lcd_ack s%0d", s), lcd_ack, expLcd);
      checkOutput($sformatf("starve host_ack s%0d", s), host_ack, expHost);
      if (s == 31) checkOutput("starve count at limit", dut.u_arb.starve_q, 16);
      if (s == 33) checkOutput("starve count cleared", dut.u_arb.starve_q, 0);
      if (s == 35) checkOutput("starve host rdata", host_rdata, 8'h11);
    end

    // Plain reset clears captured data and strobes.
    rst = 1'b1; cpu_req = 1'b0; lcd_req = 1'b0; host_req = 1'b0;
    applyStimulus(1);
    checkOutput("rst2 phase", phase, 0);
    checkOutput("rst2 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
    checkOutput("rst2 rdata", {cpu_rdata, lcd_rdata, host_rdata}, 0);
    checkOutput("rst2 acks", {cpu_ack, lcd_ack, host_ack}, 0);

    // Reset hits phase 1 of a CPU write.
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00042; cpu_wdata = 8'h99;
    applyStimulus(1);
    checkOutput("cpu wr phase", phase, 0);
    checkOutput("cpu wr ram_a", ram_a, 19'h00042);
    checkOutput("cpu wr ram_di", ram_di, 8'h99);
    checkOutput("cpu wr p0 strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b011);
    applyStimulus(1);
    checkOutput("cpu wr p1 we_n", ram_we_n, 0);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("abort we_n", ram_we_n, 1);
    checkOutput("abort ce_n", ram_ce_n, 1);
    checkOutput("abort phase", phase, 0);
    checkOutput("abort ack", cpu_ack, 0);
    rst = 1'b0; cpu_req = 1'b0;
    applyStimulus(1);
    checkOutput("abort post phase", phase, 0);
    checkOutput("abort post ack", cpu_ack, 0);
    applyStimulus(1);
    checkOutput("abort post phase1", phase, 1);
    applyStimulus(1);
    checkOutput("abort post ack p2", cpu_ack, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: cpu_req in 1, cpu_we in 1, cpu_addr in 19, cpu_wdata in 8, cpu_rdata out 8, cpu_ack out 1  (Z80 requester).
REQ-003 SHALL have ports: lcd_req in 1, lcd_addr in 19, lcd_rdata out 8, lcd_ack out 1  (screen fetch requester, read-only).
REQ-004 SHALL have ports: host_req in 1, host_we in 1, host_addr in 19, host_wdata in 8, host_rdata out 8, host_ack out 1  (loader/debug requester).
REQ-005 SHALL have ports: ram_a out 19, ram_di out 8, ram_do in 8, ram_ce_n out 1, ram_oe_n out 1, ram_we_n out 1  (512KB internal RAM).
REQ-006 SHALL have ports: phase out 2  (current slot phase, debug).
REQ-007 SHALL have parameter STARVE_LIMIT, default 16, meaning the number of consecutive lost slots after which host is forced in.

Function
REQ-008 Phase counter SHALL count 0,1,2,3,0 every clk; slot A = phases 0-1, owner cpu; slot B = phases 2-3, owner lcd.
REQ-009 Grant SHALL be decided at each edge entering phase 0 or 2 from requests sampled at that edge: owner if requesting; else host if requesting; else idle.
REQ-010 A requester whose access completes at the same edge SHALL be masked from that grant decision (no double issue on held req).
REQ-011 Host SHALL win slot A over cpu when its starvation counter equals STARVE_LIMIT; counter increments per slot boundary with host_req high and not granted, saturates, clears on host grant.
REQ-012 Edge entering even phase with grant: ram_a<=addr, ram_ce_n<=0, ram_oe_n<=we, ram_we_n<=1, ram_di<=wdata.
REQ-013 Edge entering odd phase: ram_we_n<=~we of granted access; ram_a, ram_di, ram_ce_n, ram_oe_n held.
REQ-014 Edge ending odd phase: read captures ram_do into the granted requester's rdata; ack pulses high exactly 1 cycle; ram_we_n<=1; ram_ce_n/ram_oe_n<=1 unless a new grant drives them.
REQ-015 rdata SHALL hold until that requester's next read ack; writes SHALL leave rdata unchanged.
REQ-016 Latency: req high at owner-slot edge -> ack 2 cycles later; worst case cpu/lcd 6 cycles from req rise.
REQ-017 Requester SHALL keep req, we, addr, wdata stable until ack; dropping req before ack is illegal (no required behaviour).
REQ-018 All outputs SHALL be registered; no combinational path input->output.

Reset
REQ-019 While rst sampled high: phase=0, grant idle, starve counter 0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_a=0, ram_di=0, all rdata=0, all ack=0.
REQ-020 Reset mid-access SHALL abort it: no ack, ram_we_n high at the first edge rst is sampled; first post-reset cycle is phase 0 with grant decision.

Structure
REQ-021 Package mem_sched_pkg SHALL hold requester ID enum (NONE, CPU, LCD, HOST), phase constants, address width 19, data width 8.
REQ-022 Grant decision and starvation counter SHALL live in sub-module mem_sched_arb; memory strobes/capture in mem_sched.

Verification
REQ-023 rst 3 cycles, no req -> phase 0,1,2,3,0 repeating; ram_ce_n constant 1; acks 0.
REQ-024 cpu read 0x12345, ram_do=0xA5 -> ram_a=0x12345, ce_n/oe_n low phases 0-1, we_n high; cpu_ack at phase 2 with cpu_rdata=0xA5.
REQ-025 host write 0x7FFFF data 0x3C, lcd idle -> granted slot B; ram_we_n low only in phase 3; ram_di=0x3C; host_ack in phase 0.
REQ-026 cpu, lcd, host all held high -> alternating cpu/lcd acks every 4 cycles; after 16 lost slots host takes slot A, cpu ack delayed 4 cycles, counter back to 0.
REQ-027 cpu_req held high across ack -> exactly one access per 4 cycles, no access in slot B from cpu.
REQ-028 rst asserted in phase 1 of cpu write -> ram_we_n=1 next cycle, no cpu_ack, phase 0 after release.
